prbs_engine: RTL and testbench
==============================

PRBS_ENGINE -- requirements
Module: prbs_engine

Interface
REQ-001 Parameter POLY, 31, PRBS order; legal 7, 15, 23, 31; taps x^7+x^6+1, x^15+x^14+1, x^23+x^18+1, x^31+x^28+1.
REQ-002 Parameter W, 8, bits produced/checked per beat; legal 1..32.
REQ-003 Parameter ERR_CNT_W, 16, error counter width.
REQ-004 Parameter LOCK_BEATS, 4, consecutive clean beats needed to lock.
REQ-005 Parameter UNLOCK_BEATS, 4, consecutive errored beats needed to drop lock.
REQ-006 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-007 seed_load  in  1  load seed into generator state.
REQ-008 seed  in  POLY  seed value.
REQ-009 out_valid  out  1 / out_ready  in  1 / out_data  out  W  generator stream; out_data[W-1] is the earliest bit.
REQ-010 chk_valid  in  1 / chk_data  in  W  checker input, same bit order.
REQ-011 chk_clr  in  1  clear error counter.
REQ-012 chk_locked  out  1 / chk_err  out  1 / chk_err_cnt  out  ERR_CNT_W  checker status.

Function
REQ-013 One LFSR step SHALL be: new = s[POLY-1] ^ s[TAP-1]; s <= {s[POLY-2:0], new}; emitted bit = new.
REQ-014 out_data SHALL equal the next W emitted bits from the current state, combinational from the state register; the state SHALL advance exactly W steps per beat with out_valid && out_ready.
REQ-015 out_data SHALL hold stable while out_valid && !out_ready.
REQ-016 out_valid SHALL be 0 during reset and 1 from the first cycle after reset deasserts.
REQ-017 seed_load SHALL override any same-cycle advance; an all-zero seed SHALL load all-ones; new data SHALL be visible the next cycle.
REQ-018 The checker SHALL be self-synchronising: per received bit r[k], error bit e[k] = r[k] ^ r[k-POLY] ^ r[k-TAP], using a POLY-bit history of received bits.
REQ-019 The history SHALL be "filled" only after at least POLY bits have been received since reset; until then, error bits SHALL be ignored.
REQ-020 The checker FSM SHALL have states HUNT and LOCKED.
REQ-021 In HUNT, after LOCK_BEATS consecutive filled beats with zero error bits, the FSM SHALL enter LOCKED; any errored beat SHALL restart the count.
REQ-022 In LOCKED, after UNLOCK_BEATS consecutive beats with nonzero errors, the FSM SHALL enter HUNT; any clean beat SHALL restart the count.
REQ-023 In LOCKED only, chk_err_cnt SHALL add the popcount of the beat's error bits, saturating at all-ones.
REQ-024 chk_clr SHALL zero the counter and take priority over a same-cycle increment.
REQ-025 chk_err SHALL pulse one cycle after a LOCKED beat with nonzero errors.
REQ-026 chk_locked SHALL be 1 in the LOCKED state; cycles without chk_valid SHALL change nothing.

Reset
REQ-027 Reset SHALL set generator state to all-ones, out_valid 0, history empty, FSM HUNT, chk_locked 0, chk_err 0, chk_err_cnt 0, both beat counters 0.
REQ-028 Reset mid-stream SHALL discard all in-flight state; the first beat after reset SHALL equal the first beat after power-up.

Configuration
REQ-029 With PRBS_CHECKER_EN defined, the checker (REQ-018..026) SHALL be compiled in.
REQ-030 Without PRBS_CHECKER_EN, the checker logic SHALL be absent: chk_locked, chk_err and chk_err_cnt SHALL tie to 0, and chk inputs SHALL be ignored.

Structure
REQ-031 Package prbs_pkg SHALL hold the legal-order list, the tap lookup function (POLY -> TAP), the checker state enum and the all-ones seed constant.
REQ-032 Sub-module prbs_advance (combinational W-step LFSR advance returning next state and W bits) SHALL be instantiated by the generator.

Verification
REQ-033 POLY=7, W=8, reset, out_ready=1 -> first out_data 8'h02; stream period 127 bits; no all-zero state.
REQ-034 POLY=31, W=8, reset -> first three beats 8'h00; out_ready=0 for 5 cycles -> out_data unchanged.
REQ-035 seed_load with seed=0 -> same output as post-reset; seed_load together with a handshake -> the load wins.
REQ-036 Generator looped to checker, POLY=7, W=8 -> chk_locked=1 after fill plus 4 clean beats; chk_err_cnt stays 0.
REQ-037 In LOCKED, flip one bit once -> chk_err_cnt +3 and chk_err pulses; 4 beats of all-flipped random data -> chk_locked=0.
REQ-038 Counter at max with errors -> holds all-ones; chk_clr together with errors -> 0.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared definitions for the PRBS generator/checker slice.
//
// Contents:
//   LEGAL_ORDERS   list of supported PRBS orders (7, 15, 23, 31)
//   tap_of()       PRBS order -> second feedback tap
//   is_legal_order() membership test against LEGAL_ORDERS
//   chk_state_t    checker FSM state (HUNT / LOCKED)
//   SEED_ONES      all-ones seed, sliced to the order in use
package prbs_pkg;

  localparam int NUM_ORDERS = 4;
  localparam int LEGAL_ORDERS [NUM_ORDERS] = '{7, 15, 23, 31};

  // Wide enough for the largest order; users slice [POLY-1:0].
  localparam logic [31:0] SEED_ONES = '1;

  typedef enum logic {
    CHK_HUNT   = 1'b0,
    CHK_LOCKED = 1'b1
  } chk_state_t;

  // Polynomials x^P + x^T + 1; returns T for order P, 0 for an unknown order.
  function automatic int tap_of(input int poly);
    case (poly)
      7:       return 6;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_legal_order(input int poly);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_ORDERS; i++) begin
      if (LEGAL_ORDERS[i] == poly) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/prbs_if.sv
// prbs_if -- bundle of the generator stream, seed control and checker I/O.
//
// Handshake: a generator beat transfers on a rising clk edge where
// out_valid && out_ready are both 1. out_data must not change while
// out_valid is high and out_ready is low. The checker side has no back
// pressure: every edge with chk_valid=1 consumes one chk_data beat.
//
// Signals (direction as seen by the engine, modport master):
//   seed_load  in   load seed into the generator state
//   seed       in   POLY-bit seed (zero loads all-ones)
//   out_valid  out  generator beat available
//   out_ready  in   consumer accepts the beat
//   out_data   out  W bits, out_data[W-1] is the earliest bit
//   chk_valid  in   checker beat present
//   chk_data   in   W received bits, same bit order as out_data
//   chk_clr    in   clear the error counter
//   chk_locked out  checker in LOCKED
//   chk_err    out  one-cycle pulse after an errored LOCKED beat
//   chk_err_cnt out saturating error bit count
//   chk_state  out  checker FSM state, for observation
interface prbs_if
  import prbs_pkg::*;
#(
  parameter int POLY      = 31,
  parameter int W         = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 seed_load;
  logic [POLY-1:0]      seed;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic                 chk_valid;
  logic [W-1:0]         chk_data;
  logic                 chk_clr;
  logic                 chk_locked;
  logic                 chk_err;
  logic [ERR_CNT_W-1:0] chk_err_cnt;
  chk_state_t           chk_state;

  modport master (
    input  seed_load, seed, out_ready, chk_valid, chk_data, chk_clr,
    output out_valid, out_data, chk_locked, chk_err, chk_err_cnt, chk_state
  );

  modport slave (
    output seed_load, seed, out_ready, chk_valid, chk_data, chk_clr,
    input  out_valid, out_data, chk_locked, chk_err, chk_err_cnt, chk_state
  );
endinterface

// File: rtl/prbs_advance.sv
// prbs_advance -- combinational W-step Fibonacci LFSR advance.
//
// One step: new = s[POLY-1] ^ s[TAP-1]; s = {s[POLY-2:0], new}; emit new.
// Ports:
//   state      in   current LFSR state
//   next_state out  state after W steps
//   bits       out  the W emitted bits, bits[W-1] emitted first
module prbs_advance
  import prbs_pkg::*;
#(
  parameter int POLY = 31,
  parameter int W    = 8
) (
  input  logic [POLY-1:0] state,
  output logic [POLY-1:0] next_state,
  output logic [W-1:0]    bits
);

  localparam int TAP = tap_of(POLY);

  logic [POLY-1:0] s_work;
  logic            new_bit;

  always_comb begin
    s_work  = state;
    new_bit = 1'b0;
    bits    = '0;
    for (int i = 0; i < W; i++) begin
      new_bit     = s_work[POLY-1] ^ s_work[TAP-1];
      s_work      = {s_work[POLY-2:0], new_bit};
      bits[W-1-i] = new_bit;
    end
    next_state = s_work;
  end

endmodule

// File: rtl/prbs_engine.sv
// prbs_engine -- PRBS generator with an optional self-synchronising checker.
//
// Build option: define PRBS_CHECKER_EN to compile the checker in. Without
// it the checker status outputs read 0 and the chk_* inputs are ignored.
//
// Ports:
//   clk  in  clock
//   rst  in  synchronous, active-high reset
//   bus  prbs_if.master  seed control, generator stream, checker I/O
//
// Parameters: POLY (7/15/23/31), W (1..32 bits per beat), ERR_CNT_W,
// LOCK_BEATS, UNLOCK_BEATS.
module prbs_engine
  import prbs_pkg::*;
#(
  parameter int POLY         = 31,
  parameter int W            = 8,
  parameter int ERR_CNT_W    = 16,
  parameter int LOCK_BEATS   = 4,
  parameter int UNLOCK_BEATS = 4
) (
  input  logic    clk,
  input  logic    rst,
  prbs_if.master  bus
);

  if (!is_legal_order(POLY)) begin : g_bad_poly
    $error("prbs_engine: unsupported POLY order");
  end

  // ---------------------------------------------------------------------
  // Generator
  // ---------------------------------------------------------------------
  logic [POLY-1:0] gen_state;
  logic [POLY-1:0] gen_next;
  logic [W-1:0]    gen_bits;
  logic            out_valid_q;
  logic            gen_fire;

  prbs_advance #(
    .POLY (POLY),
    .W    (W)
  ) u_advance (
    .state      (gen_state),
    .next_state (gen_next),
    .bits       (gen_bits)
  );

  assign gen_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_state   <= SEED_ONES[POLY-1:0];
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b1;
      // A seed load beats a same-cycle handshake; zero would lock the LFSR.
      if (bus.seed_load) begin
        gen_state <= (bus.seed == '0) ? SEED_ONES[POLY-1:0] : bus.seed;
      end else if (gen_fire) begin
        gen_state <= gen_next;
      end
    end
  end

  // out_data is a function of the state register only, so it is stable
  // for as long as the state is not advanced.
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = gen_bits;

`ifdef PRBS_CHECKER_EN
  // ---------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------
  localparam int TAP    = tap_of(POLY);
  localparam int FILL_W = $clog2(POLY + W + 1);
  localparam int LCNT_W = (LOCK_BEATS > 1) ? $clog2(LOCK_BEATS + 1) : 1;
  localparam int UCNT_W = (UNLOCK_BEATS > 1) ? $clog2(UNLOCK_BEATS + 1) : 1;
  localparam int POP_W  = $clog2(W + 1);
  localparam int SUM_W  = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;

  chk_state_t           chk_state;
  logic [POLY-1:0]      hist;        // hist[0] is the oldest received bit
  logic [POLY-1:0]      hist_next;
  logic [FILL_W-1:0]    fill_cnt;
  logic                 filled;
  logic [LCNT_W-1:0]    lock_cnt;
  logic [UCNT_W-1:0]    unlock_cnt;
  logic                 chk_locked_q;
  logic                 chk_err_q;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [POLY+W-1:0]    seq;
  logic [W-1:0]         err_bits;
  logic [POP_W-1:0]     err_pop;
  logic                 err_any;
  logic [SUM_W-1:0]     err_sum;
  logic                 beat_live;

  assign filled    = (fill_cnt >= FILL_W'(POLY));
  assign beat_live = bus.chk_valid && filled;

  // seq lays the history and the new beat out in arrival order, so the
  // bit received POLY (or TAP) positions earlier is a fixed index away.
  always_comb begin
    seq       = '0;
    err_bits  = '0;
    err_pop   = '0;
    hist_next = '0;
    err_any   = 1'b0;
    err_sum   = '0;
    seq[POLY-1:0] = hist;
    for (int i = 0; i < W; i++) begin
      seq[POLY+i] = bus.chk_data[W-1-i];
    end
    for (int i = 0; i < W; i++) begin
      err_bits[i] = seq[POLY+i] ^ seq[i] ^ seq[POLY+i-TAP];
      err_pop     = err_pop + POP_W'(err_bits[i]);
    end
    hist_next = seq[W +: POLY];
    err_any   = |err_bits;
    err_sum   = SUM_W'(err_cnt) + SUM_W'(err_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_state    <= CHK_HUNT;
      hist         <= '0;
      fill_cnt     <= '0;
      lock_cnt     <= '0;
      unlock_cnt   <= '0;
      chk_locked_q <= 1'b0;
      chk_err_q    <= 1'b0;
      err_cnt      <= '0;
    end else begin
      chk_err_q <= 1'b0;

      if (bus.chk_valid) begin
        hist <= hist_next;
        if (!filled) fill_cnt <= fill_cnt + FILL_W'(W);
      end

      if (beat_live) begin
        case (chk_state)
          CHK_HUNT: begin
            if (err_any) begin
              lock_cnt <= '0;
            end else if (lock_cnt == LCNT_W'(LOCK_BEATS - 1)) begin
              chk_state    <= CHK_LOCKED;
              chk_locked_q <= 1'b1;
              lock_cnt     <= '0;
              unlock_cnt   <= '0;
            end else begin
              lock_cnt <= lock_cnt + LCNT_W'(1);
            end
          end
          CHK_LOCKED: begin
            chk_err_q <= err_any;
            if (!err_any) begin
              unlock_cnt <= '0;
            end else if (unlock_cnt == UCNT_W'(UNLOCK_BEATS - 1)) begin
              chk_state    <= CHK_HUNT;
              chk_locked_q <= 1'b0;
              unlock_cnt   <= '0;
              lock_cnt     <= '0;
            end else begin
              unlock_cnt <= unlock_cnt + UCNT_W'(1);
            end
          end
          default: begin
            chk_state    <= CHK_HUNT;
            chk_locked_q <= 1'b0;
          end
        endcase
      end

      // Clear wins over a same-cycle increment; counting only while locked.
      if (bus.chk_clr) begin
        err_cnt <= '0;
      end else if (beat_live && chk_state == CHK_LOCKED) begin
        if (err_sum > SUM_W'({ERR_CNT_W{1'b1}})) err_cnt <= '1;
        else                                     err_cnt <= err_sum[ERR_CNT_W-1:0];
      end
    end
  end

  assign bus.chk_locked  = chk_locked_q;
  assign bus.chk_err     = chk_err_q;
  assign bus.chk_err_cnt = err_cnt;
  assign bus.chk_state   = chk_state;
`else
  logic unused_chk;
  assign unused_chk      = ^{bus.chk_valid, bus.chk_data, bus.chk_clr};
  assign bus.chk_locked  = 1'b0;
  assign bus.chk_err     = 1'b0;
  assign bus.chk_err_cnt = '0;
  assign bus.chk_state   = CHK_HUNT;
`endif

endmodule

// File: tb/tb_prbs_engine.sv
module tb_prbs_engine;
  import prbs_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  prbs_if #(.POLY(7),  .W(8), .ERR_CNT_W(6))  bus7 ();
  prbs_if #(.POLY(31), .W(8), .ERR_CNT_W(16)) bus31 ();

  prbs_engine #(
    .POLY(7), .W(8), .ERR_CNT_W(6), .LOCK_BEATS(4), .UNLOCK_BEATS(4)
  ) dut7 (
    .clk (clk),
    .rst (rst),
    .bus (bus7.master)
  );

  prbs_engine #(
    .POLY(31), .W(8), .ERR_CNT_W(16), .LOCK_BEATS(4), .UNLOCK_BEATS(4)
  ) dut31 (
    .clk (clk),
    .rst (rst),
    .bus (bus31.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle_inputs();
    bus7.seed_load  = 1'b0;  bus7.seed  = '0;  bus7.out_ready  = 1'b0;
    bus7.chk_valid  = 1'b0;  bus7.chk_data = '0; bus7.chk_clr  = 1'b0;
    bus31.seed_load = 1'b0;  bus31.seed = '0;  bus31.out_ready = 1'b0;
    bus31.chk_valid = 1'b0;  bus31.chk_data = '0; bus31.chk_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One loopback beat on dut7: generator beat handed to the checker,
  // optionally corrupted by mask.
  task automatic loop_beat(input logic [7:0] mask, input logic clr);
    bus7.out_ready = 1'b1;
    bus7.chk_valid = 1'b1;
    bus7.chk_data  = bus7.out_data ^ mask;
    bus7.chk_clr   = clr;
    @(posedge clk);
    @(negedge clk);
    bus7.out_ready = 1'b0;
    bus7.chk_valid = 1'b0;
    bus7.chk_clr   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus7.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid7: got %0b want 0", bus7.out_valid);
    end
    total++;
    if (bus31.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid31: got %0b want 0", bus31.out_valid);
    end
    total++;
    if ({bus7.chk_locked, bus7.chk_err, bus7.chk_err_cnt} !== 8'h00) begin
      bad++; $display("FAIL reset_chk: got %0b %0b %0h want 0 0 0",
                      bus7.chk_locked, bus7.chk_err, bus7.chk_err_cnt);
    end
    total++;
    if (bus7.chk_state !== CHK_HUNT) begin
      bad++; $display("FAIL reset_state: got %0d want HUNT", bus7.chk_state);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus7.out_valid !== 1'b1 || bus31.out_valid !== 1'b1) begin
      bad++; $display("FAIL post_reset_valid: got %0b %0b want 1 1",
                      bus7.out_valid, bus31.out_valid);
    end
    total++;
    if (bus7.out_data !== 8'h02) begin
      bad++; $display("FAIL first_beat7: got %0h want 02", bus7.out_data);
    end
    total++;
    if (bus31.out_data !== 8'h00) begin
      bad++; $display("FAIL first_beat31: got %0h want 00", bus31.out_data);
    end
  endtask

  task automatic test_stream7();
    logic [7:0] first_exp [3];
    logic       b [320];
    int         valid_bad;
    int         period_bad;
    int         zrun;
    int         zrun_max;
    first_exp = '{8'h02, 8'h0C, 8'h28};
    valid_bad = 0;
    do_reset();
    bus7.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i < 3) begin
        total++;
        if (bus7.out_data !== first_exp[i]) begin
          bad++; $display("FAIL stream7_beat%0d: got %0h want %0h",
                          i, bus7.out_data, first_exp[i]);
        end
      end
      if (bus7.out_valid !== 1'b1) valid_bad++;
      for (int j = 0; j < 8; j++) b[i*8+j] = bus7.out_data[7-j];
      @(posedge clk);
      @(negedge clk);
    end
    bus7.out_ready = 1'b0;
    period_bad = 0;
    for (int n = 0; n < 320 - 127; n++) begin
      if (b[n] !== b[n+127]) period_bad++;
    end
    zrun = 0;
    zrun_max = 0;
    for (int n = 0; n < 320; n++) begin
      zrun = (b[n] == 1'b0) ? zrun + 1 : 0;
      if (zrun > zrun_max) zrun_max = zrun;
    end
    total++;
    if (valid_bad !== 0) begin
      bad++; $display("FAIL stream7_valid: got %0d drops want 0", valid_bad);
    end
    total++;
    if (period_bad !== 0) begin
      bad++; $display("FAIL stream7_period: got %0d mismatches want 0", period_bad);
    end
    total++;
    if (zrun_max > 6) begin
      bad++; $display("FAIL stream7_zero_run: got %0d want <=6", zrun_max);
    end
  endtask

  task automatic test_backpressure31();
    logic [7:0] after_exp [5];
    after_exp = '{8'h0E, 8'h00, 8'h00, 8'h00, 8'hFC};
    do_reset();
    bus31.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus31.out_data !== 8'h00) begin
        bad++; $display("FAIL bp31_beat%0d: got %0h want 00", i, bus31.out_data);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus31.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (bus31.out_data !== 8'h0E || bus31.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp31_stall%0d: got %0h/%0b want 0E/1",
                        i, bus31.out_data, bus31.out_valid);
      end
    end
    bus31.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus31.out_data !== after_exp[i]) begin
        bad++; $display("FAIL bp31_resume%0d: got %0h want %0h",
                        i, bus31.out_data, after_exp[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus31.out_ready = 1'b0;
  endtask

  task automatic test_seed_load();
    do_reset();
    bus7.out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (bus7.out_data !== 8'h28) begin
      bad++; $display("FAIL seed_pre: got %0h want 28", bus7.out_data);
    end
    // zero seed together with a handshake
    bus7.seed_load = 1'b1;
    bus7.seed      = 7'h00;
    @(posedge clk);
    @(negedge clk);
    bus7.seed_load = 1'b0;
    bus7.out_ready = 1'b0;
    total++;
    if (bus7.out_data !== 8'h02) begin
      bad++; $display("FAIL seed_zero: got %0h want 02", bus7.out_data);
    end
    bus7.seed_load = 1'b1;
    bus7.seed      = 7'h01;
    bus7.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus7.seed_load = 1'b0;
    total++;
    if (bus7.out_data !== 8'h06) begin
      bad++; $display("FAIL seed_one: got %0h want 06", bus7.out_data);
    end
    @(posedge clk);
    @(negedge clk);
    bus7.out_ready = 1'b0;
    total++;
    if (bus7.out_data !== 8'h14) begin
      bad++; $display("FAIL seed_one_next: got %0h want 14", bus7.out_data);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus7.out_ready  = 1'b1;
    bus31.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus7.out_valid !== 1'b0 || bus31.out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_valid: got %0b %0b want 0 0",
                      bus7.out_valid, bus31.out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus7.out_data !== 8'h02 || bus31.out_data !== 8'h00 || bus7.out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_reset_first: got %0h %0h v%0b want 02 00 v1",
                      bus7.out_data, bus31.out_data, bus7.out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus7.out_data !== 8'h0C) begin
      bad++; $display("FAIL mid_reset_second: got %0h want 0C", bus7.out_data);
    end
    bus7.out_ready  = 1'b0;
    bus31.out_ready = 1'b0;
  endtask

`ifdef PRBS_CHECKER_EN
  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      loop_beat(8'h00, 1'b0);
      total++;
      if (bus7.chk_locked !== 1'b0) begin
        bad++; $display("FAIL lock_early%0d: got %0b want 0", i, bus7.chk_locked);
      end
    end
    loop_beat(8'h00, 1'b0);
    total++;
    if (bus7.chk_locked !== 1'b1 || bus7.chk_state !== CHK_LOCKED) begin
      bad++; $display("FAIL lock_reached: got %0b/%0d want 1/LOCKED",
                      bus7.chk_locked, bus7.chk_state);
    end
    // idle cycles with junk on chk_data change nothing
    bus7.chk_data = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus7.chk_locked !== 1'b1 || bus7.chk_err_cnt !== 6'd0 || bus7.chk_err !== 1'b0) begin
      bad++; $display("FAIL lock_idle: got %0b cnt %0d err %0b want 1 0 0",
                      bus7.chk_locked, bus7.chk_err_cnt, bus7.chk_err);
    end
  endtask

  task automatic test_single_flip();
    loop_beat(8'h80, 1'b0);
    total++;
    if (bus7.chk_err_cnt !== 6'd3 || bus7.chk_err !== 1'b1) begin
      bad++; $display("FAIL flip_one: got cnt %0d err %0b want 3 1",
                      bus7.chk_err_cnt, bus7.chk_err);
    end
    loop_beat(8'h00, 1'b0);
    total++;
    if (bus7.chk_err_cnt !== 6'd3 || bus7.chk_err !== 1'b0 || bus7.chk_locked !== 1'b1) begin
      bad++; $display("FAIL flip_after: got cnt %0d err %0b lk %0b want 3 0 1",
                      bus7.chk_err_cnt, bus7.chk_err, bus7.chk_locked);
    end
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 3; i++) begin
      loop_beat(8'hFF, 1'b0);
      total++;
      if (bus7.chk_locked !== 1'b1) begin
        bad++; $display("FAIL unlock_early%0d: got %0b want 1", i, bus7.chk_locked);
      end
    end
    loop_beat(8'hFF, 1'b0);
    total++;
    if (bus7.chk_locked !== 1'b0 || bus7.chk_state !== CHK_HUNT || bus7.chk_err !== 1'b1) begin
      bad++; $display("FAIL unlock: got lk %0b st %0d err %0b want 0 HUNT 1",
                      bus7.chk_locked, bus7.chk_state, bus7.chk_err);
    end
    total++;
    if (bus7.chk_err_cnt !== 6'd34) begin
      bad++; $display("FAIL unlock_cnt: got %0d want 34", bus7.chk_err_cnt);
    end
  endtask

  task automatic test_saturate_clr();
    // first good beat still sees one error from the corrupted history
    for (int i = 0; i < 4; i++) loop_beat(8'h00, 1'b0);
    total++;
    if (bus7.chk_locked !== 1'b0) begin
      bad++; $display("FAIL relock_early: got %0b want 0", bus7.chk_locked);
    end
    loop_beat(8'h00, 1'b0);
    total++;
    if (bus7.chk_locked !== 1'b1 || bus7.chk_err_cnt !== 6'd34) begin
      bad++; $display("FAIL relock: got lk %0b cnt %0d want 1 34",
                      bus7.chk_locked, bus7.chk_err_cnt);
    end
    // each round: 7 + 8 + 1 + 0 errors, three errored beats keep the lock
    for (int r = 0; r < 3; r++) begin
      loop_beat(8'hFF, 1'b0);
      loop_beat(8'hFF, 1'b0);
      loop_beat(8'h00, 1'b0);
      loop_beat(8'h00, 1'b0);
      total++;
      if (bus7.chk_err_cnt !== ((r == 0) ? 6'd50 : 6'd63) || bus7.chk_locked !== 1'b1) begin
        bad++; $display("FAIL sat_round%0d: got cnt %0d lk %0b want %0d 1",
                        r, bus7.chk_err_cnt, bus7.chk_locked, (r == 0) ? 50 : 63);
      end
    end
    loop_beat(8'hFF, 1'b1);
    total++;
    if (bus7.chk_err_cnt !== 6'd0 || bus7.chk_err !== 1'b1) begin
      bad++; $display("FAIL clr_with_err: got cnt %0d err %0b want 0 1",
                      bus7.chk_err_cnt, bus7.chk_err);
    end
    loop_beat(8'h00, 1'b0);
    total++;
    if (bus7.chk_err_cnt !== 6'd1) begin
      bad++; $display("FAIL clr_after: got %0d want 1", bus7.chk_err_cnt);
    end
  endtask
`else
  task automatic test_checker_off();
    do_reset();
    for (int i = 0; i < 6; i++) loop_beat((i > 2) ? 8'hFF : 8'h00, 1'b0);
    loop_beat(8'h80, 1'b0);
    total++;
    if ({bus7.chk_locked, bus7.chk_err, bus7.chk_err_cnt} !== 8'h00) begin
      bad++; $display("FAIL chk_off: got %0b %0b %0h want 0 0 0",
                      bus7.chk_locked, bus7.chk_err, bus7.chk_err_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_stream7();
    test_backpressure31();
    test_seed_load();
    test_reset_midstream();
`ifdef PRBS_CHECKER_EN
    test_lock();
    test_single_flip();
    test_unlock();
    test_saturate_clr();
`else
    test_checker_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
